// File: rtl/gate_vector_checker.sv
// gate_vector_checker
// Drives the four input combinations of a two-input gate block, waits a
// settle window on each, then compares the twelve gate outputs against an
// expected truth table and reports a per-run summary.
module gate_vector_checker #(
    parameter int unsigned SETTLE    = 2,
    parameter logic [47:0] EXP_TABLE = 48'hB23_596_A56_8EC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a_out,
    output logic        b_out,
    input  logic [11:0] y_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_count,
    output logic [11:0] err_mask,
    output logic [3:0]  fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Settle counter is loaded with SETTLE-1 so HOLD lasts SETTLE cycles and
    // the CHECK cycle makes the total drive window SETTLE+1 cycles.
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t      state;
    logic [1:0]  vec;
    logic [3:0]  cnt;
    logic [11:0] exp_word;
    logic [11:0] diff;
    logic        mismatch;

    // Expected word for the vector currently applied, and the comparison.
    // The case-inequality makes an unknown bit on y_in count as a mismatch.
    always_comb begin
        exp_word = EXP_TABLE[12*vec +: 12];
        diff     = y_in ^ exp_word;
        mismatch = (y_in !== exp_word);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 2'd0;
            cnt       <= 4'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            err_mask  <= 12'h000;
            fail_vec  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // Results and the (1,1) drive of the previous run stay
                    // visible until a new run is actually accepted.
                    if (start) begin
                        state     <= HOLD;
                        busy      <= 1'b1;
                        vec       <= 2'd0;
                        a_out     <= 1'b0;
                        b_out     <= 1'b0;
                        cnt       <= RELOAD;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        err_mask  <= 12'h000;
                        fail_vec  <= 4'b0000;
                    end
                end

                HOLD: begin
                    if (cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        err_count     <= err_count + 3'd1;
                        fail_vec[vec] <= 1'b1;
                        err_mask      <= err_mask | diff;
                    end
                    if (vec != 2'd3) begin
                        vec            <= vec + 2'd1;
                        {a_out, b_out} <= vec + 2'd1;
                        cnt            <= RELOAD;
                        state          <= HOLD;
                    end else begin
                        // Verdict folds in the final vector so it is already
                        // valid while done is high.
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_count == 3'd0) && !mismatch;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Testbench for gate_vector_checker: behavioural gate model with fault
// injection, table-driven fault cases, corner-case sequences and random runs.
module tb_gate_vector_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic        a_out, b_out;
    logic [11:0] y_in;
    logic        busy, done, pass;
    logic [2:0]  err_count;
    logic [11:0] err_mask;
    logic [3:0]  fail_vec;

    logic        start1;
    logic        a1, b1;
    logic [11:0] y1;
    logic        busy1, done1, pass1;
    logic [2:0]  cnt1;
    logic [11:0] mask1;
    logic [3:0]  fv1;

    // Fault injection controls for the main gate model
    logic [11:0] sa0, sa1, inv;
    logic [11:0] xm [4];

    int tests;
    int fails;

    gate_vector_checker #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
        .y_in(y_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .err_mask(err_mask), .fail_vec(fail_vec)
    );

    gate_vector_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
        .y_in(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(cnt1), .err_mask(mask1), .fail_vec(fv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference two-input gate behaviour, one output per gate function
    function automatic logic [11:0] gold(input logic a, input logic b);
        logic [11:0] y;
        y[0]  = a & b;
        y[1]  = a | b;
        y[2]  = ~(a & b);
        y[3]  = ~(a | b);
        y[4]  = a ^ b;
        y[5]  = ~(a ^ b);
        y[6]  = ~a;
        y[7]  = ~b;
        y[8]  = a;
        y[9]  = b;
        y[10] = a & ~b;
        y[11] = ~a | b;
        return y;
    endfunction

    function automatic logic [11:0] faulty(input logic a, input logic b);
        return (((gold(a, b) & ~sa0) | sa1) ^ inv) ^ xm[{a, b}];
    endfunction

    assign y_in = faulty(a_out, b_out);
    assign y1   = gold(a1, b1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-run expectation from the current fault settings
    task automatic model(output logic [2:0] ec, output logic [3:0] fv,
                         output logic [11:0] mk, output logic ps);
        int n;
        n  = 0;
        fv = 4'b0000;
        mk = 12'h000;
        for (int v = 0; v < 4; v++) begin
            logic [11:0] d;
            d = faulty(v[1], v[0]) ^ gold(v[1], v[0]);
            if (d != 12'h000) begin
                n++;
                fv[v] = 1'b1;
            end
            mk |= d;
        end
        ec = 3'(n);
        ps = (n == 0);
    endtask

    // One run on the SETTLE=2 instance; lat = negedge index of done after
    // the acceptance edge, -1 if it never came. Optionally pulses start
    // during the run.
    task automatic do_run(input bit noisy, output int lat, output bit ab_ok, output bit busy_ok);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat     = -1;
        ab_ok   = 1'b1;
        busy_ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (noisy) start = (k < 11) && (k % 4 == 1);
            if (done) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (k < 12) begin
                if ({a_out, b_out} != 2'(k / 3)) ab_ok = 1'b0;
                if (!busy) busy_ok = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [11:0] sa0;
        logic [11:0] sa1;
        logic [11:0] inv;
        logic [2:0]  cnt;
        logic [3:0]  fv;
        logic [11:0] mask;
        logic        pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int lat;
        bit ab_ok, busy_ok;
        logic [2:0]  ec;
        logic [3:0]  fv;
        logic [11:0] mk;
        logic        ps;
        int ndone, d1, d2;

        tests = 0;
        fails = 0;
        sa0 = 12'h000; sa1 = 12'h000; inv = 12'h000;
        for (int v = 0; v < 4; v++) xm[v] = 12'h000;
        start = 1'b0;
        start1 = 1'b0;

        tbl[0] = '{"good",      12'h000, 12'h000, 12'h000, 3'd0, 4'b0000, 12'h000, 1'b1};
        tbl[1] = '{"xor_sa0",   12'h010, 12'h000, 12'h000, 3'd2, 4'b0110, 12'h010, 1'b0};
        tbl[2] = '{"all_inv",   12'h000, 12'h000, 12'hFFF, 3'd4, 4'b1111, 12'hFFF, 1'b0};
        tbl[3] = '{"y12_sa1",   12'h000, 12'h800, 12'h000, 3'd1, 4'b0100, 12'h800, 1'b0};
        tbl[4] = '{"and_sa1",   12'h000, 12'h001, 12'h000, 3'd3, 4'b0111, 12'h001, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ab", 32'({a_out, b_out}), 32'd0);
        chk("rst_outs", 32'({done, pass, err_count, err_mask, fail_vec}), 32'd0);
        rst = 1'b0;

        // Table-driven fault cases
        for (int i = 0; i < 5; i++) begin
            sa0 = tbl[i].sa0; sa1 = tbl[i].sa1; inv = tbl[i].inv;
            do_run(1'b0, lat, ab_ok, busy_ok);
            chk({tbl[i].name, "_lat"}, 32'(lat), 32'd12);
            chk({tbl[i].name, "_ab_seq"}, 32'(ab_ok), 32'd1);
            chk({tbl[i].name, "_busy"}, 32'(busy_ok), 32'd1);
            chk({tbl[i].name, "_cnt"}, 32'(err_count), 32'(tbl[i].cnt));
            chk({tbl[i].name, "_fv"}, 32'(fail_vec), 32'(tbl[i].fv));
            chk({tbl[i].name, "_mask"}, 32'(err_mask), 32'(tbl[i].mask));
            chk({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].pass));
            @(negedge clk);
            chk({tbl[i].name, "_done_1cyc"}, 32'(done), 32'd0);
            chk({tbl[i].name, "_ab_hold"}, 32'({a_out, b_out}), 32'd3);
        end
        sa0 = 12'h000; sa1 = 12'h000; inv = 12'h000;

        // Reset while vector 2 is in HOLD, with errors already accumulated
        inv = 12'hFFF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_ab", 32'({a_out, b_out}), 32'd2);
        chk("pre_rst_cnt", 32'(err_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ab", 32'({a_out, b_out}), 32'd0);
        chk("async_rst_outs", 32'({done, pass, err_count, err_mask, fail_vec}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        inv = 12'h000;
        do_run(1'b0, lat, ab_ok, busy_ok);
        chk("post_rst_lat", 32'(lat), 32'd12);
        chk("post_rst_pass", 32'(pass), 32'd1);

        // Start pulsed during a run: exactly one done
        do_run(1'b1, lat, ab_ok, busy_ok);
        chk("noisy_lat", 32'(lat), 32'd12);
        chk("noisy_ab_seq", 32'(ab_ok), 32'd1);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("noisy_extra_done", 32'(ndone), 32'd0);
        chk("noisy_idle_busy", 32'(busy), 32'd0);

        // Start held high: back-to-back runs, results cleared at acceptance
        sa0 = 12'h010;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        d1 = -1;
        d2 = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("b2b_run1_cnt", 32'(err_count), 32'd2);
                    chk("b2b_run1_pass", 32'(pass), 32'd0);
                    sa0 = 12'h000;
                end else begin
                    d2 = k;
                    start = 1'b0;
                    chk("b2b_run2_pass", 32'(pass), 32'd1);
                    chk("b2b_run2_cnt", 32'(err_count), 32'd0);
                    break;
                end
            end
            if (d1 >= 0 && k == d1 + 2) begin
                chk("b2b_cleared", 32'({err_count, err_mask, fail_vec}), 32'd0);
                chk("b2b_restart_ab", 32'({a_out, b_out}), 32'd0);
                chk("b2b_restart_busy", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        chk("b2b_done1", 32'(d1), 32'd12);
        chk("b2b_done2", 32'(d2), 32'd26);

        // SETTLE=1 instance: two cycles per vector, done after edge 8
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        lat = -1;
        ab_ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done1) begin
                lat = k;
                break;
            end
            if (k < 8 && {a1, b1} != 2'(k / 2)) ab_ok = 1'b0;
        end
        chk("s1_lat", 32'(lat), 32'd8);
        chk("s1_ab_seq", 32'(ab_ok), 32'd1);
        chk("s1_pass", 32'(pass1), 32'd1);

        // Randomized per-vector faults against the reference model
        for (int r = 0; r < 16; r++) begin
            for (int v = 0; v < 4; v++) begin
                case ($urandom_range(0, 3))
                    0: xm[v] = 12'(32'd1 << $urandom_range(0, 11));
                    1: xm[v] = 12'($urandom);
                    default: xm[v] = 12'h000;
                endcase
            end
            model(ec, fv, mk, ps);
            do_run(1'b0, lat, ab_ok, busy_ok);
            chk("rand_lat", 32'(lat), 32'd12);
            chk("rand_cnt", 32'(err_count), 32'(ec));
            chk("rand_fv", 32'(fail_vec), 32'(fv));
            chk("rand_mask", 32'(err_mask), 32'(mk));
            chk("rand_pass", 32'(pass), 32'(ps));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
